// File: rtl/systolic_skew_feeder.sv
// Input feeder for the systolic multiply-add array: buffers row vectors in a small FIFO and
// presents them to the array rows with a diagonal skew (lane r trails lane 0 by r advances).
// At end of stream the skew is drained with bubbles and done pulses for one cycle.
module systolic_skew_feeder #(
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*DATA_SIZE-1:0] in_data,
  input  logic                      in_last,
  input  logic                      out_ready,
  output logic                      out_enable,
  output logic [ROWS*DATA_SIZE-1:0] out_data,
  output logic [ROWS-1:0]           out_valid,
  output logic                      done
);

  localparam int unsigned Aw   = $clog2(FIFO_DEPTH);
  localparam int unsigned Vw   = ROWS * DATA_SIZE;
  localparam int unsigned CntW = (ROWS > 2) ? $clog2(ROWS - 1) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStream = 2'd1;
  localparam logic [1:0] StFlush  = 2'd2;

  // FIFO storage: entry = {last, vector}. Pointers carry one wrap bit for full/empty.
  logic [Vw:0]     mem_q [FIFO_DEPTH];
  logic [Aw:0]     wr_ptr_q, wr_ptr_d;
  logic [Aw:0]     rd_ptr_q, rd_ptr_d;
  logic            full, empty, push, pop, advance, flushing;
  logic [Vw:0]     head_entry;
  logic [Vw-1:0]   head_vec;
  logic            head_last;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q == {~rd_ptr_q[Aw], rd_ptr_q[Aw-1:0]});
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign flushing   = (state_q == StFlush);
  // Bubbles need no FIFO data, so FLUSH advances whenever the consumer is ready.
  assign advance    = out_ready && (flushing || !empty);
  assign pop        = advance && !flushing;
  assign out_enable = advance;
  assign done       = done_q;

  assign head_entry = mem_q[rd_ptr_q[Aw-1:0]];
  assign head_vec   = head_entry[Vw-1:0];
  assign head_last  = head_entry[Vw];

  // FIFO entry write; storage needs no reset since the pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[Aw-1:0]] <= {in_last, in_data};
    end
  end

  // Next-state for FIFO pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + (Aw + 1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (Aw + 1)'(1);
  end

  // Stream control: pop until a last entry, then drain ROWS-1 bubbles and flag done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle, StStream: begin
        if (pop) state_d = head_last ? StFlush : StStream;
      end
      StFlush: begin
        if (advance) begin
          if (cnt_q == CntW'(ROWS - 2)) begin
            cnt_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and pointer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // Per-lane skew chains: lane r holds r+1 stages; the last stage drives the array.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_SIZE-1:0] data_q [r+1];
    logic [r:0]           vld_q;
    logic [DATA_SIZE-1:0] head_data;

    assign head_data = flushing ? '0 : head_vec[r*DATA_SIZE +: DATA_SIZE];

    // Shift the chain on every advance; the head takes the popped lane or a bubble.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j <= r; j++) data_q[j] <= '0;
        vld_q <= '0;
      end else if (advance) begin
        data_q[0] <= head_data;
        vld_q[0]  <= !flushing;
        for (int j = 1; j <= r; j++) begin
          data_q[j] <= data_q[j-1];
          vld_q[j]  <= vld_q[j-1];
        end
      end
    end

    assign out_data[r*DATA_SIZE +: DATA_SIZE] = data_q[r];
    assign out_valid[r]                       = vld_q[r];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: cycle table for a single vector, directed corner cases and
// randomized traffic against a vector-history reference model.
module tb_systolic_skew_feeder;

  localparam int DS = 32;
  localparam int R  = 4;
  localparam int D  = 4;
  localparam int W  = R * DS;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_enable;
  logic [W-1:0] out_data;
  logic [R-1:0] out_valid;
  logic         done;

  systolic_skew_feeder #(.DATA_SIZE(DS), .ROWS(R), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_ready (out_ready),
    .out_enable(out_enable),
    .out_data  (out_data),
    .out_valid (out_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of buffered vectors, last R items fed to the array (newest first),
  // and number of bubbles still owed after a last vector.
  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } ent_t;

  ent_t         mq[$];
  logic [W-1:0] hd [R];
  bit           hv [R];
  int           bub;
  bit           mdone;
  bit           last_acc;

  typedef struct {
    logic         vld;
    logic         last;
    logic         ordy;
    logic [W-1:0] data;
    logic         e_irdy;
    logic         e_oe;
    logic         e_done;
    logic [R-1:0] e_ov;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int j = 0; j < R; j++) begin
      hd[j] = '0;
      hv[j] = 1'b0;
    end
    bub      = 0;
    mdone    = 1'b0;
    last_acc = 1'b0;
  endtask

  // Wait for the falling edge and compare all outputs with the model.
  task automatic to_neg();
    logic [W-1:0] eod;
    logic [R-1:0] eov;
    @(negedge clk);
    eod = '0;
    eov = '0;
    for (int r = 0; r < R; r++) begin
      eod[r*DS +: DS] = hd[r][r*DS +: DS];
      eov[r]          = hv[r];
    end
    chk("model in_ready", W'(in_ready), W'(mq.size() < D));
    chk("model out_enable", W'(out_enable), W'(out_ready && (bub > 0 || mq.size() > 0)));
    chk("model out_valid", W'(out_valid), W'(eov));
    chk("model out_data", out_data, eod);
    chk("model done", W'(done), W'(mdone));
  endtask

  // Cross the rising edge and update the model from the pre-edge inputs.
  task automatic to_pos();
    bit   adv;
    bit   acc;
    ent_t e;
    adv = out_ready && (bub > 0 || mq.size() > 0);
    acc = in_valid && (mq.size() < D);
    @(posedge clk);
    mdone = 1'b0;
    if (adv) begin
      for (int j = R - 1; j > 0; j--) begin
        hd[j] = hd[j-1];
        hv[j] = hv[j-1];
      end
      if (bub > 0) begin
        hd[0] = '0;
        hv[0] = 1'b0;
        bub--;
        if (bub == 0) mdone = 1'b1;
      end else begin
        e     = mq.pop_front();
        hd[0] = e.data;
        hv[0] = 1'b1;
        if (e.last) bub = R - 1;
      end
    end
    if (acc) mq.push_back({in_last, in_data});
    last_acc = acc;
    #1;
  endtask

  task automatic cyc();
    to_neg();
    to_pos();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  function automatic logic [W-1:0] kvec(input int k);
    logic [W-1:0] v;
    for (int r = 0; r < R; r++) v[r*DS +: DS] = DS'(10 * k + r);
    return v;
  endfunction

  function automatic logic [W-1:0] rvec();
    logic [W-1:0] v;
    for (int r = 0; r < R; r++) v[r*DS +: DS] = $urandom;
    return v;
  endfunction

  initial begin
    logic [W-1:0] v1;
    logic [W-1:0] z;
    int           nxt;
    z  = '0;
    v1 = {32'd4, 32'd3, 32'd2, 32'd1};
    model_reset();

    // Reset values while reset is held.
    #2;
    chk("rst in_ready", W'(in_ready), W'(1'b1));
    chk("rst out_enable", W'(out_enable), W'(1'b0));
    chk("rst out_valid", W'(out_valid), W'(4'b0000));
    chk("rst out_data", out_data, z);
    chk("rst done", W'(done), W'(1'b0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    // Idle for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      to_neg();
      chk("idle out_enable", W'(out_enable), W'(1'b0));
      chk("idle out_valid", W'(out_valid), W'(4'b0000));
      to_pos();
    end

    // Single last vector: cycle-by-cycle expected outputs.
    tbl[0] = '{1'b1, 1'b1, 1'b1, v1, 1'b1, 1'b0, 1'b0, 4'b0000, z};
    tbl[1] = '{1'b0, 1'b0, 1'b1, z, 1'b1, 1'b1, 1'b0, 4'b0000, z};
    tbl[2] = '{1'b0, 1'b0, 1'b1, z, 1'b1, 1'b1, 1'b0, 4'b0001, {96'd0, 32'd1}};
    tbl[3] = '{1'b0, 1'b0, 1'b1, z, 1'b1, 1'b1, 1'b0, 4'b0010, {64'd0, 32'd2, 32'd0}};
    tbl[4] = '{1'b0, 1'b0, 1'b1, z, 1'b1, 1'b1, 1'b0, 4'b0100, {32'd0, 32'd3, 64'd0}};
    tbl[5] = '{1'b0, 1'b0, 1'b1, z, 1'b1, 1'b0, 1'b1, 4'b1000, {32'd4, 96'd0}};
    tbl[6] = '{1'b0, 1'b0, 1'b1, z, 1'b1, 1'b0, 1'b0, 4'b1000, {32'd4, 96'd0}};
    for (int i = 0; i < 7; i++) begin
      in_valid  = tbl[i].vld;
      in_last   = tbl[i].last;
      in_data   = tbl[i].data;
      out_ready = tbl[i].ordy;
      to_neg();
      chk($sformatf("tbl[%0d] in_ready", i), W'(in_ready), W'(tbl[i].e_irdy));
      chk($sformatf("tbl[%0d] out_enable", i), W'(out_enable), W'(tbl[i].e_oe));
      chk($sformatf("tbl[%0d] done", i), W'(done), W'(tbl[i].e_done));
      chk($sformatf("tbl[%0d] out_valid", i), W'(out_valid), W'(tbl[i].e_ov));
      chk($sformatf("tbl[%0d] out_data", i), out_data, tbl[i].e_od);
      to_pos();
    end

    // Four back-to-back vectors: full diagonal after the fourth pop.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_last  = (k == 3);
      in_data  = kvec(k);
      cyc();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    cyc();
    to_neg();
    chk("b2b diagonal data", out_data, {32'd3, 32'd12, 32'd21, 32'd30});
    chk("b2b diagonal valid", W'(out_valid), W'(4'b1111));
    to_pos();
    for (int i = 0; i < 6; i++) cyc();

    // Back-pressure: consumer stalls 5 cycles while the FIFO fills.
    do_reset();
    out_ready = 1'b1;
    nxt       = 0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = kvec(nxt);
      cyc();
      if (last_acc) nxt++;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = kvec(nxt);
      to_neg();
      chk("stall out_enable", W'(out_enable), W'(1'b0));
      if (i >= 3) chk("stall in_ready full", W'(in_ready), W'(1'b0));
      to_pos();
      if (last_acc) nxt++;
    end
    out_ready = 1'b1;
    in_data   = kvec(nxt);
    to_neg();
    chk("resume no pass-through", W'(in_ready), W'(1'b0));
    to_pos();
    if (last_acc) nxt++;
    in_data = kvec(nxt);
    in_last = 1'b1;
    to_neg();
    chk("resume in_ready", W'(in_ready), W'(1'b1));
    to_pos();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 14; i++) cyc();

    // Underflow gap of 3 cycles between vectors 2 and 3.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = kvec(k);
      cyc();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      if (i >= 1) chk("gap out_enable", W'(out_enable), W'(1'b0));
      to_pos();
    end
    for (int k = 2; k < 4; k++) begin
      in_valid = 1'b1;
      in_last  = (k == 3);
      in_data  = kvec(k);
      cyc();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    cyc();
    to_neg();
    chk("gap realign data", out_data, {32'd3, 32'd12, 32'd21, 32'd30});
    to_pos();
    for (int i = 0; i < 6; i++) cyc();

    // Async reset during FLUSH with the bubble counter at 1.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_data   = v1;
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
    cyc();
    cyc();
    #2;
    reset = 1'b0;
    #1;
    chk("async in_ready", W'(in_ready), W'(1'b1));
    chk("async out_enable", W'(out_enable), W'(1'b0));
    chk("async out_valid", W'(out_valid), W'(4'b0000));
    chk("async out_data", out_data, z);
    chk("async done", W'(done), W'(1'b0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) cyc();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 9) < 2);
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = rvec();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
